ram_scan_reader: RTL and testbench

- Read-side counterpart to the switch-driven nibble RAM writer: walks the 32x4 RAM read port address by address and presents each (address, data) pair for the 7-segment converters.
- Two advance modes: timed auto-scan from a prescaler, or single-step on a key edge.
- Sits between the RAM read port and the display converters in the lab top level.

---
 rtl/ram_scan_reader_if.sv | 24 ++
 rtl/ram_scan_reader.sv | 109 ++++++++++
 tb/tb_ram_scan_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_scan_reader_if.sv
// RAM read port and display bundle between ram_scan_reader, the nibble RAM
// and the 7-segment converters.
interface ram_scan_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4
) ();
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              wrap;

   modport master (
      output rd_en, rd_addr, disp_addr, disp_data, disp_valid, wrap,
      input  rd_data
   );

   modport slave (
      input  rd_en, rd_addr, disp_addr, disp_data, disp_valid, wrap,
      output rd_data
   );
endinterface

// File: rtl/ram_scan_reader.sv
// Walks the RAM read port one address per trigger (prescaler tick or key edge)
// and latches each (address, data) pair for display. SCAN_DIR_EN adds a dir input.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a trigger; rd_en low, outputs hold
// ISSUE   | rd_en high for one cycle with rd_addr = cur_addr
// CAPTURE | registered RAM data valid; latch display, advance cur_addr
module ram_scan_reader #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 4,
   parameter int DEPTH    = 32,
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic step,
`ifdef SCAN_DIR_EN
   input  logic dir,
`endif
   ram_scan_reader_if.master bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]     P_LAST = PW'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [PW-1:0]     prescaler;
   logic              step_q;

   logic              tick;
   logic              step_edge;
   logic              trigger;
   logic [ADDR_W-1:0] next_addr;
   logic              at_wrap;

   assign tick      = (prescaler == P_LAST);
   assign step_edge = step & ~step_q;
   // run selects the source, so a key edge while auto-scanning is ignored
   assign trigger   = (run & tick) | (~run & step_edge);

   always_comb begin
      at_wrap   = (cur_addr == A_LAST);
      next_addr = at_wrap ? '0 : cur_addr + ADDR_W'(1);
`ifdef SCAN_DIR_EN
      if (dir) begin
         at_wrap   = (cur_addr == '0);
         next_addr = at_wrap ? A_LAST : cur_addr - ADDR_W'(1);
      end
`endif
   end

   // Free-running while auto-scanning, including while a read is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         step_q    <= 1'b0;
      end else begin
         step_q <= step;
         if (!run || tick)
            prescaler <= '0;
         else
            prescaler <= prescaler + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cur_addr       <= '0;
         bus.rd_en      <= 1'b0;
         bus.rd_addr    <= '0;
         bus.disp_addr  <= '0;
         bus.disp_data  <= '0;
         bus.disp_valid <= 1'b0;
         bus.wrap       <= 1'b0;
      end else begin
         bus.rd_en <= 1'b0;
         bus.wrap  <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  bus.rd_en   <= 1'b1;
                  bus.rd_addr <= cur_addr;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               bus.disp_data  <= bus.rd_data;
               bus.disp_addr  <= cur_addr;
               bus.disp_valid <= 1'b1;
               bus.wrap       <= at_wrap;
               cur_addr       <= next_addr;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a registered 32x4 RAM model (mem[i] = i % 16).
module tb_ram_scan_reader;

   logic clk = 1'b0;
   logic rst_n;
   logic run;
   logic step;
`ifdef SCAN_DIR_EN
   logic dir;
`endif

   int n_vec = 0;
   int n_err = 0;

   ram_scan_reader_if #(.ADDR_W(5), .DATA_W(4)) bus ();

   ram_scan_reader #(
      .ADDR_W(5), .DATA_W(4), .DEPTH(32), .TICK_DIV(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .step (step),
`ifdef SCAN_DIR_EN
      .dir  (dir),
`endif
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [3:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = 4'(i % 16);

   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   int rd_cnt = 0;
   int wrap_cnt = 0;
   logic [4:0] wrap_addr = '0;
   logic [3:0] wrap_data = '0;
   always @(negedge clk) begin
      if (bus.rd_en) rd_cnt++;
      if (bus.wrap) begin
         wrap_cnt++;
         wrap_addr = bus.disp_addr;
         wrap_data = bus.disp_data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int r0;
      rst_n = 1'b0; run = 1'b1; step = 1'b0;
`ifdef SCAN_DIR_EN
      dir = 1'b0;
`endif
      #2;
      r0 = rd_cnt;
      for (int i = 0; i < 10; i++) begin
         step = ~step;
         cyc(1);
      end
      n_vec++;
      if (rd_cnt - r0 !== 0) begin
         n_err++; $display("FAIL reset_rd_en: pulses=%0d required=0", rd_cnt - r0);
      end
      n_vec++;
      if ({bus.rd_addr, bus.disp_addr, bus.disp_data, bus.disp_valid, bus.wrap} !== 16'd0) begin
         n_err++; $display("FAIL reset_outputs: addr=%0d disp=%0d/%0d valid=%0b wrap=%0b required all 0",
            bus.rd_addr, bus.disp_addr, bus.disp_data, bus.disp_valid, bus.wrap);
      end
      run = 1'b0; step = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(6);
      n_vec++;
      if (rd_cnt - r0 !== 0 || {bus.rd_addr, bus.disp_addr, bus.disp_data, bus.disp_valid, bus.wrap} !== 16'd0) begin
         n_err++; $display("FAIL post_reset_idle: pulses=%0d disp=%0d/%0d valid=%0b required no reads, all 0",
            rd_cnt - r0, bus.disp_addr, bus.disp_data, bus.disp_valid);
      end
   endtask

   task automatic test_single_step();
      int r0 = rd_cnt;
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         cyc(1);
         n_vec++;
         if (bus.rd_en !== 1'b1 || bus.rd_addr !== 5'(i)) begin
            n_err++; $display("FAIL step_issue[%0d]: rd_en=%0b rd_addr=%0d required 1/%0d", i, bus.rd_en, bus.rd_addr, i);
         end
         cyc(1);
         n_vec++;
         if (bus.rd_en !== 1'b0) begin
            n_err++; $display("FAIL step_rd_pulse[%0d]: rd_en=%0b required 0", i, bus.rd_en);
         end
         n_vec++;
         if (i == 0 ? (bus.disp_valid !== 1'b0) : (bus.disp_addr !== 5'(i - 1))) begin
            n_err++; $display("FAIL step_early[%0d]: valid=%0b disp_addr=%0d required no update yet", i, bus.disp_valid, bus.disp_addr);
         end
         cyc(1);
         n_vec++;
         if (bus.disp_addr !== 5'(i) || bus.disp_data !== 4'(i) || bus.disp_valid !== 1'b1) begin
            n_err++; $display("FAIL step_disp[%0d]: disp=%0d/%0d valid=%0b required %0d/%0d/1",
               i, bus.disp_addr, bus.disp_data, bus.disp_valid, i, i);
         end
         step = 1'b0;
         cyc(7);
      end
      n_vec++;
      if (rd_cnt - r0 !== 3) begin
         n_err++; $display("FAIL step_count: pulses=%0d required 3", rd_cnt - r0);
      end
   endtask

   // cur_addr is 3; the second edge lands in CAPTURE and must be dropped.
   task automatic test_dropped_trigger();
      int r0 = rd_cnt;
      step = 1'b1; cyc(1);
      step = 1'b0; cyc(1);
      step = 1'b1; cyc(1);
      step = 1'b0; cyc(8);
      n_vec++;
      if (rd_cnt - r0 !== 1) begin
         n_err++; $display("FAIL dropped_count: pulses=%0d required 1", rd_cnt - r0);
      end
      n_vec++;
      if (bus.disp_addr !== 5'd3 || bus.disp_data !== 4'd3) begin
         n_err++; $display("FAIL dropped_disp: disp=%0d/%0d required 3/3", bus.disp_addr, bus.disp_data);
      end
      step = 1'b1; cyc(3);
      n_vec++;
      if (bus.disp_addr !== 5'd4 || bus.disp_data !== 4'd4) begin
         n_err++; $display("FAIL dropped_advance: disp=%0d/%0d required 4/4", bus.disp_addr, bus.disp_data);
      end
      step = 1'b0; cyc(5);
   endtask

   // cur_addr is 5; 35 ticks read addresses 5..39 mod 32 and wrap once at 31.
   task automatic test_auto_scan();
      int r0 = rd_cnt;
      int w0 = wrap_cnt;
      int bad = 0;
      run = 1'b1;
      for (int j = 0; j < 35; j++) begin
         cyc(4);
         if (bus.rd_en !== 1'b1 || bus.rd_addr !== 5'((5 + j) % 32)) begin
            bad++;
            if (bad == 1)
               $display("FAIL auto_read[%0d]: rd_en=%0b rd_addr=%0d required 1/%0d", j, bus.rd_en, bus.rd_addr, (5 + j) % 32);
         end
      end
      n_vec++;
      if (bad !== 0) n_err++;
      run = 1'b0;
      cyc(4);
      n_vec++;
      if (rd_cnt - r0 !== 35) begin
         n_err++; $display("FAIL auto_count: pulses=%0d required 35", rd_cnt - r0);
      end
      n_vec++;
      if (wrap_cnt - w0 !== 1) begin
         n_err++; $display("FAIL auto_wrap_count: wraps=%0d required 1", wrap_cnt - w0);
      end
      n_vec++;
      if (wrap_addr !== 5'd31 || wrap_data !== 4'd15) begin
         n_err++; $display("FAIL auto_wrap_disp: disp=%0d/%0d required 31/15", wrap_addr, wrap_data);
      end
      n_vec++;
      if (bus.disp_addr !== 5'd7 || bus.disp_data !== 4'd7 || bus.wrap !== 1'b0) begin
         n_err++; $display("FAIL auto_final: disp=%0d/%0d wrap=%0b required 7/7/0", bus.disp_addr, bus.disp_data, bus.wrap);
      end
   endtask

   task automatic test_reset_mid_read();
      rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
      step = 1'b1; cyc(2);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.rd_en !== 1'b0 || bus.disp_data !== 4'd0 || bus.disp_valid !== 1'b0 || bus.rd_addr !== 5'd0) begin
         n_err++; $display("FAIL midread_abort: rd_en=%0b disp_data=%0d valid=%0b rd_addr=%0d required all 0",
            bus.rd_en, bus.disp_data, bus.disp_valid, bus.rd_addr);
      end
      step = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      // Advance cur_addr with two steps so a missed reset of cur_addr shows up.
      step = 1'b1; cyc(1);
      n_vec++;
      if (bus.rd_en !== 1'b1 || bus.rd_addr !== 5'd0) begin
         n_err++; $display("FAIL midread_restart: rd_en=%0b rd_addr=%0d required 1/0", bus.rd_en, bus.rd_addr);
      end
      cyc(2);
      step = 1'b0; cyc(4);
      step = 1'b1; cyc(3);
      n_vec++;
      if (bus.disp_addr !== 5'd1 || bus.disp_data !== 4'd1) begin
         n_err++; $display("FAIL midread_next: disp=%0d/%0d required 1/1", bus.disp_addr, bus.disp_data);
      end
      step = 1'b0; cyc(4);
   endtask

`ifdef SCAN_DIR_EN
   task automatic test_dir();
      rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
      dir = 1'b1;
      step = 1'b1; cyc(1);
      n_vec++;
      if (bus.rd_addr !== 5'd0) begin
         n_err++; $display("FAIL dir_first_addr: rd_addr=%0d required 0", bus.rd_addr);
      end
      cyc(2);
      n_vec++;
      if (bus.wrap !== 1'b1 || bus.disp_addr !== 5'd0) begin
         n_err++; $display("FAIL dir_wrap: wrap=%0b disp_addr=%0d required 1/0", bus.wrap, bus.disp_addr);
      end
      step = 1'b0; cyc(1);
      n_vec++;
      if (bus.wrap !== 1'b0) begin
         n_err++; $display("FAIL dir_wrap_width: wrap=%0b required 0", bus.wrap);
      end
      cyc(3);
      step = 1'b1; cyc(3);
      n_vec++;
      if (bus.disp_addr !== 5'd31 || bus.disp_data !== 4'd15) begin
         n_err++; $display("FAIL dir_next: disp=%0d/%0d required 31/15", bus.disp_addr, bus.disp_data);
      end
      step = 1'b0; dir = 1'b0; cyc(3);
   endtask
`endif

   initial begin
      test_reset();
      test_single_step();
      test_dropped_trigger();
      test_auto_scan();
      test_reset_mid_read();
`ifdef SCAN_DIR_EN
      test_dir();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
